// File: rtl/ui_defs_pkg.sv
// ---------------------------------------------------------------------------------------------
// ui_defs_pkg
// Shared definitions for the user-interface input conditioning blocks.
//   - btn_state_e : button debouncer FSM encoding (fixed values, visible on debug taps)
//   - Def*        : default timing constants for the 50 MHz board clock
//   - cycles_from_us() : converts a microsecond interval into board-clock cycles
// ---------------------------------------------------------------------------------------------
package ui_defs_pkg;

  localparam int unsigned ClkFreqHz = 50_000_000;

  // Converts a time interval in microseconds to a cycle count at ClkFreqHz.
  function automatic int unsigned cycles_from_us(input int unsigned us);
    return (ClkFreqHz / 1_000_000) * us;
  endfunction

  localparam int unsigned DefSyncStages      = 2;
  localparam int unsigned DefDebounceCycles  = cycles_from_us(10_000);     // 10 ms
  localparam int unsigned DefLongPressCycles = cycles_from_us(1_000_000);  // 1 s

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } btn_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// ---------------------------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchronizer bringing one asynchronous pin into the clk domain.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-low reset, clears the chain to 0
//   async_in in  asynchronous input pin
//   sync_out out synchronized copy of async_in, STAGES cycles of latency
// ---------------------------------------------------------------------------------------------
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  if (STAGES < 2) begin : g_stages_chk
    $error("bit_synchronizer: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------------------------
// button_debouncer
// Turns one raw, bouncing, asynchronous push-button into a clean debounced level plus
// single-cycle press / release / long-press pulses.
// Ports:
//   clk       in  system clock, rising edge
//   reset     in  asynchronous active-low reset
//   btn_raw   in  raw button pin, 1 = pressed
//   btn_level out debounced button state (registered)
//   btn_rise  out one-cycle pulse on the edge btn_level goes 0->1
//   btn_fall  out one-cycle pulse on the edge btn_level goes 1->0
//   btn_long  out one-cycle pulse, once per press, after LONG_PRESS_CYCLES of held level
// ---------------------------------------------------------------------------------------------
module button_debouncer
  import ui_defs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES   = DefDebounceCycles,
  parameter int unsigned LONG_PRESS_CYCLES = DefLongPressCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_long
);

  if (DEBOUNCE_CYCLES < 2) begin : g_deb_chk
    $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_long_chk
    $error("button_debouncer: LONG_PRESS_CYCLES must be at least 1");
  end

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);

  // The entry sample in IDLE/PRESSED counts as the first stable sample, so the wait state
  // needs DEBOUNCE_CYCLES-1 further samples: it commits when the counter shows D-2.
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 2);
  localparam logic [DebW-1:0]  DebOne   = DebW'(1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_PRESS_CYCLES);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

  logic       btn_sync;
  btn_state_e state_q;
  logic [DebW-1:0]  deb_cnt_q;
  logic [HoldW-1:0] hold_cnt_q;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (btn_raw),
    .sync_out (btn_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      btn_level  <= 1'b0;
      btn_rise   <= 1'b0;
      btn_fall   <= 1'b0;
      btn_long   <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
      btn_long <= 1'b0;

      // Hold timer runs whenever the debounced level is high and saturates, so the long
      // pulse fires only on the cycle the limit is first reached.
      if (btn_level && (hold_cnt_q != HoldMax)) begin
        hold_cnt_q <= hold_cnt_q + HoldOne;
        if (hold_cnt_q + HoldOne == HoldMax) begin
          btn_long <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (btn_sync) begin
            state_q   <= StPressWait;
            deb_cnt_q <= '0;
          end
        end

        StPressWait: begin
          if (!btn_sync) begin
            state_q   <= StIdle;
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DebLast) begin
            state_q    <= StPressed;
            deb_cnt_q  <= '0;
            btn_level  <= 1'b1;
            btn_rise   <= 1'b1;
            hold_cnt_q <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + DebOne;
          end
        end

        StPressed: begin
          if (!btn_sync) begin
            state_q   <= StReleaseWait;
            deb_cnt_q <= '0;
          end
        end

        StReleaseWait: begin
          if (btn_sync) begin
            state_q   <= StPressed;
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DebLast) begin
            state_q    <= StIdle;
            deb_cnt_q  <= '0;
            btn_level  <= 1'b0;
            btn_fall   <= 1'b1;
            // Overrides the hold increment above; a long pulse on this same edge still stands.
            hold_cnt_q <= '0;
          end else begin
            deb_cnt_q <= deb_cnt_q + DebOne;
          end
        end

        default: begin
          state_q   <= StIdle;
          deb_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------------------------
// tb_button_debouncer
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=8. Outputs are compared as the vector {level, rise, fall, long}
// sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------------------------
module tb_button_debouncer;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic btn_raw = 1'b1;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic btn_long;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .SYNC_STAGES       (2),
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_long  (btn_long)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (level,rise,fall,long)", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, btn_level, btn_rise, btn_fall, btn_long}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clean press from idle: level/rise land on the 6th edge counting the sampling edge.
  task automatic press_clean(input string tag);
    btn_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_outs($sformatf("%s_wait%0d", tag, i), 4'b0000);
    end
    tick();
    check_outs($sformatf("%s_rise", tag), 4'b1100);
  endtask

  // Clean release: fall on the 6th edge, then quiet.
  task automatic release_clean(input string tag);
    btn_raw = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_outs($sformatf("%s_wait%0d", tag, i), 4'b1000);
    end
    tick();
    check_outs($sformatf("%s_fall", tag), 4'b0010);
    tick();
    check_outs($sformatf("%s_idle", tag), 4'b0000);
  endtask

  logic [4:0] press_bounce;
  logic [2:0] release_bounce;

  initial begin
    press_bounce   = 5'b10101;  // applied MSB first: 1,0,1,0,1
    release_bounce = 3'b010;    // applied MSB first: 0,1,0

    // 1: button held through reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outs($sformatf("rst_held%0d", i), 4'b0000);
    end
    reset = 1'b1;
    press_clean("rst_release");
    tick();
    check_outs("rst_release_rise_low", 4'b1000);
    release_clean("rst_release_up");

    // 2: clean press
    press_clean("clean");
    tick();
    check_outs("clean_rise_low", 4'b1000);
    release_clean("clean_up");

    // 3: press bounce, timed from the last 0->1
    for (int i = 4; i >= 0; i--) begin
      btn_raw = press_bounce[i];
      tick();
      check_outs($sformatf("bounce_pat%0d", 4 - i), 4'b0000);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_outs($sformatf("bounce_wait%0d", i), 4'b0000);
    end
    tick();
    check_outs("bounce_rise", 4'b1100);
    tick();
    check_outs("bounce_rise_low", 4'b1000);
    release_clean("bounce_up");

    // 4: release bounce right after the rise; fall lands on the same edge the hold timer
    // first reaches 8, so fall and long assert together.
    press_clean("rel_bounce");
    for (int i = 2; i >= 0; i--) begin
      btn_raw = release_bounce[i];
      tick();
      check_outs($sformatf("rel_bounce_pat%0d", 2 - i), 4'b1000);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_outs($sformatf("rel_bounce_wait%0d", i), 4'b1000);
    end
    tick();
    check_outs("rel_bounce_fall_long", 4'b0011);
    tick();
    check_outs("rel_bounce_idle", 4'b0000);

    // 5: long press, single pulse 8 cycles after rise
    press_clean("long");
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_outs($sformatf("long_hold%0d", i), 4'b1000);
    end
    tick();
    check_outs("long_pulse", 4'b1001);
    for (int i = 9; i <= 14; i++) begin
      tick();
      check_outs($sformatf("long_nopulse%0d", i), 4'b1000);
    end
    release_clean("long_up");

    // 6: reset three cycles after the rise
    press_clean("mid_rst");
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_outs($sformatf("mid_rst_hold%0d", i), 4'b1000);
    end
    reset   = 1'b0;
    btn_raw = 1'b0;
    #1;
    check_outs("mid_rst_async", 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_outs($sformatf("mid_rst_in%0d", i), 4'b0000);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs($sformatf("mid_rst_after%0d", i), 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
